register_1bit: RTL and testbench

REGISTER_1BIT -- requirements
Module: register_1bit

---
 rtl/register_1bit.sv | 52 +++++
 tb/tb_register_1bit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/register_1bit.sv
// -----------------------------------------------------------------------------
// register_1bit
//
// One bit of storage with a write enable and a synchronous active-high reset.
// Several instances placed side by side, sharing clk/reset/en, make a
// multi-bit register. Each instance has its own flop and shares no state.
//
// Parameters
//   RESET_VAL : value loaded into the stored bit on any edge where reset is high.
//
// Ports
//   clk     : in  - single clock; all updates happen on its rising edge
//   reset   : in  - synchronous, active-high; beats en
//   en      : in  - write enable; when low the stored bit is held
//   newdata : in  - bit to store on an enabled edge
//   out     : out - stored bit, driven straight from the flop
// -----------------------------------------------------------------------------
module register_1bit #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic newdata,
  output logic out
);

  logic out_d;
  logic out_q;

  // Load-or-hold selection. Reset is applied in the flop itself, which gives
  // the priority order reset > en > hold.
  always_comb begin
    out_d = out_q;
    if (en) begin
      out_d = newdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= RESET_VAL;
    end else begin
      out_q <= out_d;
    end
  end

  // No logic between the flop and the port, so inputs never reach out
  // combinationally.
  assign out = out_q;

endmodule

// File: tb/tb_register_1bit.sv
// -----------------------------------------------------------------------------
// tb_register_1bit
//
// Bench for register_1bit. Three groups of instances share one clock:
//   group a : single bit, default RESET_VAL (0)
//   group b : single bit, RESET_VAL = 1
//   group w : 32 instances in parallel with shared reset/en
// Inputs change 1 time unit after a rising edge; outputs are read 1 time unit
// after the following rising edge.
// -----------------------------------------------------------------------------
module tb_register_1bit;

  // ---------------------------------------------------------------- clock
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUTs
  logic rst_a = 1'b0, en_a = 1'b0, d_a = 1'b0;
  logic q_a;
  logic rst_b = 1'b0, en_b = 1'b0, d_b = 1'b0;
  logic q_b;
  logic rst_w = 1'b0, en_w = 1'b0;
  logic [31:0] d_w = '0;
  logic [31:0] q_w;

  register_1bit u_dut_a (
    .clk     (clk),
    .reset   (rst_a),
    .en      (en_a),
    .newdata (d_a),
    .out     (q_a)
  );

  register_1bit #(.RESET_VAL(1'b1)) u_dut_b (
    .clk     (clk),
    .reset   (rst_b),
    .en      (en_b),
    .newdata (d_b),
    .out     (q_b)
  );

  for (genvar g = 0; g < 32; g++) begin : g_bits
    register_1bit u_bit (
      .clk     (clk),
      .reset   (rst_w),
      .en      (en_w),
      .newdata (d_w[g]),
      .out     (q_w[g])
    );
  end

  // ---------------------------------------------------------------- bookkeeping
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle to the sampling point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic rst;
    logic en;
    logic d;
    logic exp;
  } vec_t;

  vec_t vecs[$];

  // Reference: next stored value from the stated rules, for any width.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic rst,
                                           input logic en, input logic [31:0] d,
                                           input logic [31:0] rval);
    if (rst)     return rval;
    else if (en) return d;
    else         return cur;
  endfunction

  logic        model_a;
  logic [31:0] model_w;

  initial begin
    // -------------------------------------------------------- table (group a)
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0}); // reset beats en/newdata
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1}); // load 1
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1}); // hold x3
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0}); // load 0
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1}); // load 1
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1}); // reload same value
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0}); // reset with en low
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0}); // reset held a second edge
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0}); // newdata ignored when disabled
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1}); // first write after reset
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0}); // reset and en both high

    #1;
    foreach (vecs[i]) begin
      rst_a = vecs[i].rst;
      en_a  = vecs[i].en;
      d_a   = vecs[i].d;
      tick();
      check($sformatf("vec%0d", i), {31'b0, q_a}, {31'b0, vecs[i].exp});
    end

    // -------------------------------------------------------- group b: RESET_VAL=1
    rst_b = 1'b1; en_b = 1'b0; d_b = 1'b0;
    tick();
    check("b_reset_val1", {31'b0, q_b}, 32'd1);
    rst_b = 1'b0; en_b = 1'b1; d_b = 1'b0;
    tick();
    check("b_load0", {31'b0, q_b}, 32'd0);
    // Reset pulse entirely between edges must not reach the flop.
    en_b = 1'b0;
    #2 rst_b = 1'b1;
    #2 rst_b = 1'b0;
    #1 en_b = 1'b1; d_b = 1'b1;
    #1 en_b = 1'b0; d_b = 1'b0;
    tick();
    check("b_glitch_ignored", {31'b0, q_b}, 32'd0);
    rst_b = 1'b1;
    tick();
    check("b_reset_edge", {31'b0, q_b}, 32'd1);
    en_b = 1'b1; d_b = 1'b0;
    tick();
    check("b_reset_held", {31'b0, q_b}, 32'd1);
    rst_b = 1'b0;
    tick();
    check("b_after_release", {31'b0, q_b}, 32'd0);

    // -------------------------------------------------------- group w: 32-bit build
    rst_w = 1'b1; en_w = 1'b1; d_w = 32'hFFFF_FFFF;
    tick();
    check("w_reset", q_w, 32'h0);
    rst_w = 1'b0; en_w = 1'b1; d_w = 32'd32;
    tick();
    check("w_load32", q_w, 32'h0000_0020);
    en_w = 1'b0; d_w = 32'd1;
    tick();
    check("w_hold", q_w, 32'h0000_0020);
    en_w = 1'b1;
    tick();
    check("w_load1", q_w, 32'h0000_0001);

    // -------------------------------------------------------- random vs model
    model_a = 1'b0;          // table ended on a reset edge
    model_w = 32'h0000_0001; // last 32-bit load
    for (int i = 0; i < 300; i++) begin
      logic        r, e, d;
      logic        rw, ew;
      logic [31:0] dw;
      r  = ($urandom_range(0, 15) == 0);
      e  = $urandom_range(0, 1);
      d  = $urandom_range(0, 1);
      rw = ($urandom_range(0, 15) == 0);
      ew = $urandom_range(0, 1);
      dw = $urandom;
      rst_a = r;  en_a = e;  d_a = d;
      rst_w = rw; en_w = ew; d_w = dw;
      model_a = ref_next({31'b0, model_a}, r, e, {31'b0, d}, 32'd0) != 0;
      model_w = ref_next(model_w, rw, ew, dw, 32'd0);
      // Wiggle inputs mid-cycle; only values present at the edge count.
      #3;
      en_a = ~e; d_a = ~d; d_w = ~dw;
      #1;
      rst_a = r; en_a = e; d_a = d; d_w = dw;
      tick();
      check($sformatf("rnd_a%0d", i), {31'b0, q_a}, {31'b0, model_a});
      check($sformatf("rnd_w%0d", i), q_w, model_w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
